// File: rtl/game_pkg.sv
// Shared types and helpers for the game round countdown.
// State encodings, BCD count bundle, blank pattern, digit indices.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mo;
    logic [3:0] st;
    logic [3:0] so;
  } bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] DIG_SO = 2'd0;
  localparam logic [1:0] DIG_ST = 2'd1;
  localparam logic [1:0] DIG_MO = 2'd2;
  localparam logic [1:0] DIG_MT = 2'd3;

  function automatic bcd_t to_bcd(input int unsigned secs);
    bcd_t b;
    int unsigned m;
    int unsigned s;
    m = secs / 60;
    s = secs % 60;
    b.mt = 4'(m / 10);
    b.mo = 4'(m % 10);
    b.st = 4'(s / 10);
    b.so = 4'(s % 10);
    return b;
  endfunction

  // One-second BCD decrement with borrow chain; caller keeps it off 00:00.
  function automatic bcd_t bcd_dec(input bcd_t c);
    bcd_t r;
    r = c;
    if (c.so != 4'd0) begin
      r.so = c.so - 4'd1;
    end else begin
      r.so = 4'd9;
      if (c.st != 4'd0) begin
        r.st = c.st - 4'd1;
      end else begin
        r.st = 4'd5;
        if (c.mo != 4'd0) begin
          r.mo = c.mo - 4'd1;
        end else begin
          r.mo = 4'd9;
          r.mt = c.mt - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/game_countdown_seg7.sv
// BCD digit to active-low seven-segment pattern (bit0 = a).
// Ports: bcd in [3:0]; seg out [6:0]. Codes 10..15 blank.
module seg7_decode
  import game_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/game_countdown.sv
// MM:SS round countdown with 4-digit multiplexed active-low display.
// Ports: clk, rst (async, high), timer_clk/display_clk (level squares),
//   load/start/pause controls; seg[6:0], an[3:0], dp display outputs;
//   running, expired (1-clk pulse), time_up status.
// Option: GAME_COUNTDOWN_ZERO_BLANK_EN enables leading-zero blanking.
module game_countdown
  import game_pkg::*;
#(
  parameter int INIT_SECONDS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_clk,
  input  logic       display_clk,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       running,
  output logic       expired,
  output logic       time_up
);

  localparam bcd_t INIT_BCD = to_bcd(INIT_SECONDS);

  state_e     state_q, state_d;
  bcd_t       cnt_q, cnt_d;
  logic       t_q, d_q;
  logic [1:0] idx_q, idx_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       dp_q, dp_d;
  logic       running_q, running_d;
  logic       expired_q, expired_d;
  logic       time_up_q, time_up_d;

  logic       sec_tick;
  logic       scan_tick;
  logic       cnt_zero;
  logic       cnt_one;
  logic [1:0] idx_nxt;
  logic [3:0] digit;
  logic [6:0] dig_seg;
  logic       blank;

  assign sec_tick  = timer_clk & ~t_q;
  assign scan_tick = display_clk & ~d_q;
  assign cnt_zero  = (cnt_q == bcd_t'(16'h0000));
  assign cnt_one   = (cnt_q == bcd_t'(16'h0001));
  assign idx_nxt   = idx_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      cnt_d   = INIT_BCD;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start && !cnt_zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          // Pause wins over a coincident tick; that tick is dropped.
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (sec_tick && !cnt_zero) begin
            cnt_d = bcd_dec(cnt_q);
            if (cnt_one) begin
              state_d   = ST_EXPIRED;
              expired_d = 1'b1;
            end
          end
        end
        ST_PAUSED: begin
          if (pause) state_d = ST_RUN;
        end
        ST_EXPIRED: begin
          state_d = ST_EXPIRED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
    time_up_d = (state_d == ST_EXPIRED);
  end

  always_comb begin
    digit = cnt_q.so;
    unique case (idx_nxt)
      DIG_SO: digit = cnt_q.so;
      DIG_ST: digit = cnt_q.st;
      DIG_MO: digit = cnt_q.mo;
      DIG_MT: digit = cnt_q.mt;
      default: digit = cnt_q.so;
    endcase
  end

`ifdef GAME_COUNTDOWN_ZERO_BLANK_EN
  assign blank = ((idx_nxt == DIG_MT) && (cnt_q.mt == 4'd0)) ||
                 ((idx_nxt == DIG_MO) && (cnt_q.mt == 4'd0) &&
                  (cnt_q.mo == 4'd0));
`else
  assign blank = 1'b0;
`endif

  seg7_decode u_dec (
    .bcd (digit),
    .seg (dig_seg)
  );

  always_comb begin
    idx_d = idx_q;
    seg_d = seg_q;
    an_d  = an_q;
    dp_d  = dp_q;
    if (scan_tick) begin
      idx_d = idx_nxt;
      seg_d = blank ? SEG_BLANK : dig_seg;
      an_d  = ~(4'b0001 << idx_nxt);
      dp_d  = !((idx_nxt == DIG_MO) && !blank);
      // Blink the expired 00:00 with the low half of the 1 Hz square.
      if (state_q == ST_EXPIRED && !timer_clk) an_d = 4'b1111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= INIT_BCD;
      t_q       <= 1'b0;
      d_q       <= 1'b0;
      idx_q     <= 2'd3;
      seg_q     <= SEG_BLANK;
      an_q      <= 4'b1111;
      dp_q      <= 1'b1;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      t_q       <= timer_clk;
      d_q       <= display_clk;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
      running_q <= running_d;
      expired_q <= expired_d;
      time_up_q <= time_up_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = dp_q;
  assign running = running_q;
  assign expired = expired_q;
  assign time_up = time_up_q;

endmodule

// File: doc/game_countdown.md
Name: game_countdown

Overview:
- Downstream consumer of the clock divider outputs, all in the system `clk` domain.
- Treats `timer_clk` (1 Hz square) and `display_clk` (500 Hz square) as level inputs, rising-edge detected into single-cycle ticks.
- Runs an MM:SS BCD countdown for the game round and drives the 4-digit multiplexed active-low seven-segment display.
- Signals round expiry to game control.

Parameters:
- INIT_SECONDS, 60, reload value in seconds; legal range 0..5999; converted to MM:SS BCD at elaboration.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous reset, active-high
- timer_clk  in  1  1 Hz square from clock divider
- display_clk  in  1  500 Hz square from clock divider
- load  in  1  reload INIT_SECONDS, go IDLE
- start  in  1  begin countdown from IDLE
- pause  in  1  toggle RUN/PAUSED
- seg  out  7  segments a..g, active-low, bit0 = a
- an  out  4  digit anodes, active-low, bit0 = seconds ones
- dp  out  1  decimal point, active-low; lit only on digit 2 (MM.SS separator)
- running  out  1  high in RUN
- expired  out  1  one-cycle pulse on reaching 00:00
- time_up  out  1  level, high in EXPIRED

Behaviour:
- Edge detect: `t_q`/`d_q` register the previous `timer_clk`/`display_clk`.
  - `sec_tick = timer_clk & ~t_q`; `scan_tick = display_clk & ~d_q`.
  - Both previous-value registers reset to 0.
  - An input already high at reset release produces one tick on the first cycle.
- Count: four BCD registers `mt`, `mo`, `st`, `so`.
  - Decrement on `sec_tick` in RUN only.
  - `so` 0→9 with borrow; `st` 0→5 with borrow; `mo` 0→9 with borrow; `mt` decrements on borrow.
  - Never decrements below 00:00.
- FSM states: IDLE, RUN, PAUSED, EXPIRED.
  - IDLE: `start` with count ≠ 0 → RUN; `start` with count = 0 → stay IDLE.
  - RUN: `pause` → PAUSED. `sec_tick` decrements; if the pre-decrement value is 00:01 → EXPIRED, and `expired` pulses in the cycle the state registers EXPIRED.
  - PAUSED: `pause` → RUN; `sec_tick` ignored.
  - EXPIRED: only `load` or `rst` exits.
- Priority within a cycle: rst > load > start/pause > sec_tick.
  - `load` in any state: count = INIT, state = IDLE, no `expired` pulse.
  - `pause` and `sec_tick` in the same RUN cycle: enter PAUSED, tick discarded.
  - `start` with `sec_tick` from IDLE: enter RUN, no decrement that cycle.
  - `start` in RUN/PAUSED/EXPIRED is ignored; `pause` in IDLE/EXPIRED is ignored.
- Scan:
  - 2-bit index `idx` increments on `scan_tick`, wraps 3→0.
  - `seg`/`an`/`dp` are registered and update the cycle after `scan_tick`.
  - `an` = one-hot-low of the new `idx`.
- EXPIRED blink: while `timer_clk` = 0, `an` is forced to 4'b1111 (registered on `scan_tick`); `seg` shows 00:00.
- Reset values:
  - state = IDLE, count = INIT, `idx` = 3 (first `scan_tick` selects digit 0).
  - `an` = 4'b1111, `seg` = 7'h7F, `dp` = 1.
  - `running` = 0, `expired` = 0, `time_up` = 0.
- `rst` mid-count aborts immediately (asynchronous); the display blanks until the next `scan_tick`.
- Latency:
  - `sec_tick` → count update: 1 clk after the `timer_clk` rise.
  - `running`/`time_up` are registered with state.

Optional Feature:
- Macro: GAME_COUNTDOWN_ZERO_BLANK_EN
- Defined: leading-zero blanking. Digit 3 shows blank (7'h7F) when `mt` = 0; digit 2 also blanks when `mt` = `mo` = 0. The `dp` separator is suppressed whenever digit 2 is blank.
- Undefined: all four digits always shown.

Decomposition:
- Shared package `game_pkg`:
  - FSM state encodings (2-bit).
  - SEG_BLANK = 7'h7F.
  - Digit-index constants.
  - INIT-to-BCD conversion function.
- One sub-module, `seg7_decode`: combinational 4-bit BCD → 7-bit active-low segments. Codes 10..15 decode to blank.

Test Plan:
- INIT_SECONDS=5, start, 5 `timer_clk` rises → `expired` high exactly 1 clk after the 5th rise; `time_up`=1; `running`=0; count 00:00.
- INIT=61, start, 2 rises → count 00:59 (`mo` borrow to 0, `st`=5, `so`=9).
- RUN, assert `pause` in the same cycle as a `sec_tick` → PAUSED, count unchanged; 3 more rises → unchanged; `pause` → RUN.
- EXPIRED, then `load` → IDLE, count 01:00 (INIT=60), `time_up`=0, no `expired` pulse.
- 4 `scan_tick`s after reset with count 12:34 → `an` sequence 1110, 1101, 1011, 0111; `seg` shows 4, 3, 2, 1; `dp`=0 only with an=1011.
- Assert `rst` mid-RUN at 00:30 → next cycle state IDLE, count INIT, `an`=4'b1111.
